// File: rtl/ual_issue_ctrl_pkg.sv
// Shared definitions for the UAL issue controller.
//  - UAL opcode encodings (0..7 legal, 8..15 illegal and executed as mul by the UAL)
//  - issue FSM state encoding
//  - packed command layout {op, b, a} as stored in the command FIFO
//  - op_illegal(): flags opcodes outside the legal set
package ual_issue_ctrl_pkg;

    localparam logic [3:0] OP_MUL  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;

    localparam int CMD_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] b;
        logic [3:0] a;
    } cmd_t;

    // Any opcode outside the eight defined operations is reported as illegal.
    function automatic logic op_illegal(input logic [3:0] op);
        logic ill_s;
        case (op)
            OP_MUL, OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR, OP_NAND, OP_NOR: ill_s = 1'b0;
            default:                        ill_s = 1'b1;
        endcase
        return ill_s;
    endfunction

endpackage

// File: rtl/ual_cmd_fifo.sv
// Command FIFO for the UAL issue controller.
//  clk, rst_n     : clock, asynchronous active-low reset (empties the FIFO)
//  push, wdata    : write request and data; ignored while full (no full-bypass)
//  pop, rdata     : read request; rdata shows the head entry (first-word fall-through)
//  full, empty    : occupancy flags
//  count          : occupancy 0..DEPTH
// Pointers wrap modulo DEPTH, which must be a power of two.
module ual_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    // Full is judged on the registered count, so a same-cycle pop never frees a slot for a push.
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ual_issue_ctrl.sv
// Issue stage for the 4-bit UAL (ALU + Booth multiplier).
// Commands are queued in ual_cmd_fifo, issued one at a time on registered alu_a/b/op,
// and the UAL's combinational alu_c is captured ALU_LAT cycles later and held on the
// result port until the consumer takes it.
//  clk, rst_n                 : clock, asynchronous active-low reset
//  cmd_valid/cmd_ready        : command handshake; cmd_a, cmd_b, cmd_op payload
//  alu_a, alu_b, alu_op       : registered UAL inputs, held between commands
//  alu_c                      : UAL result (8 bits, taken verbatim)
//  res_valid/res_ready        : result handshake; res_c, res_op, res_ill payload
//  busy                       : command in flight or queued
//  fifo_cnt                   : FIFO occupancy
//  done_cnt                   : completed result handshakes, wrapping at 8 bits
module ual_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_a,
    input  logic [3:0]             cmd_b,
    input  logic [3:0]             cmd_op,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_op,
    input  logic [7:0]             alu_c,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [7:0]             res_c,
    output logic [3:0]             res_op,
    output logic                   res_ill,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic [7:0]             done_cnt
);

    import ual_issue_ctrl_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [LW-1:0] LAT_LOAD = LW'(ALU_LAT - 1);

    issue_state_t  state_r;
    issue_state_t  state_nx_s;
    logic          pop_s;
    logic          capture_s;
    logic          handoff_s;
    logic          lat_dec_s;
    cmd_t          head_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_cnt_s;
    logic [LW-1:0] lat_cnt_r;
    logic [3:0]    alu_a_r;
    logic [3:0]    alu_b_r;
    logic [3:0]    alu_op_r;
    logic          res_valid_r;
    logic [7:0]    res_c_r;
    logic [3:0]    res_op_r;
    logic          res_ill_r;
    logic [7:0]    done_cnt_r;

    ual_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .wdata ({cmd_op, cmd_b, cmd_a}),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_cnt_s)
    );

    assign cmd_ready = ~fifo_full_s;
    assign fifo_cnt  = fifo_cnt_s;
    assign busy      = (state_r != ST_IDLE) | ~fifo_empty_s;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_op    = alu_op_r;
    assign res_valid = res_valid_r;
    assign res_c     = res_c_r;
    assign res_op    = res_op_r;
    assign res_ill   = res_ill_r;
    assign done_cnt  = done_cnt_r;

    // Issue FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Issue FSM next state and the single-cycle strobes that drive the datapath.
    always_comb begin
        state_nx_s = state_r;
        pop_s      = 1'b0;
        capture_s  = 1'b0;
        handoff_s  = 1'b0;
        lat_dec_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_r == {LW{1'b0}}) begin
                    capture_s  = 1'b1;
                    state_nx_s = ST_HOLD;
                end else begin
                    lat_dec_s  = 1'b1;
                    state_nx_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    handoff_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // UAL operand registers and settle counter; operands keep their value until the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r   <= 4'd0;
            alu_b_r   <= 4'd0;
            alu_op_r  <= 4'd0;
            lat_cnt_r <= {LW{1'b0}};
        end else begin
            if (pop_s) begin
                alu_a_r   <= head_s.a;
                alu_b_r   <= head_s.b;
                alu_op_r  <= head_s.op;
                lat_cnt_r <= LAT_LOAD;
            end else if (lat_dec_s) begin
                lat_cnt_r <= lat_cnt_r - LW'(1);
            end
        end
    end

    // Result holding registers and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_c_r     <= 8'd0;
            res_op_r    <= 4'd0;
            res_ill_r   <= 1'b0;
            done_cnt_r  <= 8'd0;
        end else begin
            if (capture_s) begin
                res_valid_r <= 1'b1;
                res_c_r     <= alu_c;
                res_op_r    <= alu_op_r;
                res_ill_r   <= op_illegal(alu_op_r);
            end else if (handoff_s) begin
                res_valid_r <= 1'b0;
                done_cnt_r  <= done_cnt_r + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ual_issue_ctrl.sv
// Testbench for ual_issue_ctrl: a default build (ALU_LAT=1) and an ALU_LAT=3 build,
// each driving a behavioural UAL on its alu_* ports.
module tb_ual_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b, cmd_op;
    logic [3:0] alu_a, alu_b, alu_op;
    logic [7:0] alu_c;
    logic       res_valid, res_ready;
    logic [7:0] res_c;
    logic [3:0] res_op;
    logic       res_ill, busy;
    logic [2:0] fifo_cnt;
    logic [7:0] done_cnt;

    logic       c3_cmd_valid, c3_cmd_ready;
    logic [3:0] c3_cmd_a, c3_cmd_b, c3_cmd_op;
    logic [3:0] c3_alu_a, c3_alu_b, c3_alu_op;
    logic [7:0] c3_alu_c;
    logic       c3_res_valid, c3_res_ready;
    logic [7:0] c3_res_c;
    logic [3:0] c3_res_op;
    logic       c3_res_ill, c3_busy;
    logic [2:0] c3_fifo_cnt;
    logic [7:0] c3_done_cnt;

    always #5 clk = ~clk;

    // Behavioural UAL: unsigned operands, 8-bit result, illegal opcodes fall back to mul.
    function automatic logic [7:0] ual_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] op);
        logic [7:0] ax, bx, r;
        ax = {4'd0, a};
        bx = {4'd0, b};
        case (op)
            4'd1:    r = ax + bx;
            4'd2:    r = ax - bx;
            4'd3:    r = {4'd0, a & b};
            4'd4:    r = {4'd0, a | b};
            4'd5:    r = {4'd0, a ^ b};
            4'd6:    r = {4'd0, ~(a & b)};
            4'd7:    r = {4'd0, ~(a | b)};
            default: r = ax * bx;
        endcase
        return r;
    endfunction

    assign alu_c    = ual_f(alu_a, alu_b, alu_op);
    assign c3_alu_c = ual_f(c3_alu_a, c3_alu_b, c3_alu_op);

    ual_issue_ctrl #(.DEPTH(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_c(res_c), .res_op(res_op),
        .res_ill(res_ill), .busy(busy), .fifo_cnt(fifo_cnt), .done_cnt(done_cnt)
    );

    ual_issue_ctrl #(.DEPTH(4), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(c3_cmd_valid), .cmd_ready(c3_cmd_ready),
        .cmd_a(c3_cmd_a), .cmd_b(c3_cmd_b), .cmd_op(c3_cmd_op),
        .alu_a(c3_alu_a), .alu_b(c3_alu_b), .alu_op(c3_alu_op), .alu_c(c3_alu_c),
        .res_valid(c3_res_valid), .res_ready(c3_res_ready), .res_c(c3_res_c),
        .res_op(c3_res_op), .res_ill(c3_res_ill), .busy(c3_busy),
        .fifo_cnt(c3_fifo_cnt), .done_cnt(c3_done_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: accepted commands in order, results must match them.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
    } cmd_s_t;

    cmd_s_t     exp_q[$];
    cmd_s_t     mon_e;
    int         push_seen = 0;
    int         hs_seen   = 0;
    logic [7:0] done_exp  = 8'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            done_exp = 8'd0;
        end else begin
            check("ready_vs_full", 32'(cmd_ready), 32'(fifo_cnt != 3'd4));
            check("cnt_range", 32'(fifo_cnt <= 3'd4), 32'(1));
            if (fifo_cnt != 3'd0 || res_valid) begin
                check("busy", 32'(busy), 32'(1));
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_result: got res_c=0x%0h with no command outstanding",
                             res_c);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("res_c", 32'(res_c), 32'(ual_f(mon_e.a, mon_e.b, mon_e.op)));
                    check("res_op", 32'(res_op), 32'(mon_e.op));
                    check("res_ill", 32'(res_ill), 32'(mon_e.op > 4'd7));
                    check("done_cnt", 32'(done_cnt), 32'(done_exp));
                    done_exp = done_exp + 8'd1;
                    hs_seen++;
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back({cmd_a, cmd_b, cmd_op});
                push_seen++;
            end
        end
    end

    // Present one command and hold it until accepted; called just after a rising edge.
    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        int k;
        k = 0;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && k < 200) begin
            k++;
            @(negedge clk);
        end
        check("push_accept", 32'(cmd_ready), 32'(1));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Count rising edges until res_valid, bounded.
    task automatic wait_res(input int bound, output int k);
        k = 0;
        while (!res_valid && k < bound) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("res_wait", 32'(res_valid), 32'(1));
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < bound) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_busy", 32'(busy), 32'(0));
        check("drain_queue", 32'(exp_q.size()), 32'(0));
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [7:0] c;
        logic       ill;
    } vec_t;

    vec_t vt[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         base;
        int         nres;
        logic [7:0] cap;
        bit         rnd_done;

        vt[0]  = '{4'h3, 4'h5, 4'h1, 8'h08, 1'b0};
        vt[1]  = '{4'h3, 4'h2, 4'h0, 8'h06, 1'b0};
        vt[2]  = '{4'hF, 4'h1, 4'h3, 8'h01, 1'b0};
        vt[3]  = '{4'h2, 4'h3, 4'h9, 8'h06, 1'b1};
        vt[4]  = '{4'h3, 4'h5, 4'h2, 8'hFE, 1'b0};
        vt[5]  = '{4'hA, 4'hC, 4'h4, 8'h0E, 1'b0};
        vt[6]  = '{4'hA, 4'hC, 4'h5, 8'h06, 1'b0};
        vt[7]  = '{4'hA, 4'hC, 4'h6, 8'h07, 1'b0};
        vt[8]  = '{4'hA, 4'hC, 4'h7, 8'h01, 1'b0};
        vt[9]  = '{4'hF, 4'hF, 4'h0, 8'hE1, 1'b0};
        vt[10] = '{4'hF, 4'hF, 4'hF, 8'hE1, 1'b1};
        vt[11] = '{4'h9, 4'h9, 4'h1, 8'h12, 1'b0};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_op = 4'd0; res_ready = 1'b0;
        c3_cmd_valid = 1'b0; c3_cmd_a = 4'd0; c3_cmd_b = 4'd0; c3_cmd_op = 4'd0;
        c3_res_ready = 1'b0;
        rnd_done = 1'b0;

        // Reset state of both builds.
        #3;
        check("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'(0));
        check("rst_res", 32'({res_valid, res_c, res_op, res_ill}), 32'(0));
        check("rst_misc", 32'({busy, fifo_cnt, done_cnt}), 32'(0));
        check("rst_ready", 32'(cmd_ready), 32'(1));
        check("rst3_outs", 32'({c3_alu_a, c3_alu_b, c3_alu_op, c3_res_valid, c3_res_c}), 32'(0));
        check("rst3_ready", 32'(c3_cmd_ready), 32'(1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single commands through the default build, latency 2 and res_ready held high.
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push(vt[i].a, vt[i].b, vt[i].op);
            wait_res(20, k);
            check("latency", 32'(k), 32'(2));
            check("vec_c", 32'(res_c), 32'(vt[i].c));
            check("vec_op", 32'(res_op), 32'(vt[i].op));
            check("vec_ill", 32'(res_ill), 32'(vt[i].ill));
            @(posedge clk);
            #1;
            check("vec_done", 32'(done_cnt), 32'(i + 1));
        end

        // Back-to-back commands come back in order.
        fork
            begin
                push(4'h3, 4'h2, 4'h0);
                push(4'hF, 4'h1, 4'h3);
            end
        join_none
        wait_res(20, k);
        cap = res_c;
        check("b2b_first", 32'(cap), 32'(8'h06));
        @(posedge clk);
        #1;
        wait_res(20, k);
        cap = res_c;
        check("b2b_second", 32'(cap), 32'(8'h01));
        @(posedge clk);
        #1;
        drain(50);

        // Stalled consumer: one held result plus a full FIFO back-pressures the sixth command.
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push(4'(i), 4'(i + 3), 4'(i * 3));
        end
        repeat (2) @(posedge clk);
        #1;
        check("stall_cnt", 32'(fifo_cnt), 32'(4));
        check("stall_ready", 32'(cmd_ready), 32'(0));
        check("stall_hold", 32'(res_valid), 32'(1));
        base = push_seen;
        k = hs_seen;
        fork
            push(4'hE, 4'h7, 4'h0);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("sixth_blocked", 32'(push_seen), 32'(base));
                res_ready = 1'b1;
            end
        join
        drain(100);
        check("stall_results", 32'(hs_seen - k), 32'(6));

        // Reset while a command is in WAIT with three more queued.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(4'(i + 2), 4'(i + 1), 4'(i));
        end
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_cnt", 32'(fifo_cnt), 32'(4));
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(posedge clk);
        #1;
        check("wait_queued", 32'(fifo_cnt), 32'(3));
        check("wait_state", 32'({busy, res_valid}), 32'(2'b10));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_alu", 32'({alu_a, alu_b, alu_op}), 32'(0));
        check("mid_rst_res", 32'({res_valid, res_c, res_op, res_ill}), 32'(0));
        check("mid_rst_misc", 32'({busy, fifo_cnt, done_cnt}), 32'(0));
        check("mid_rst_ready", 32'(cmd_ready), 32'(1));
        @(posedge clk);
        #1 rst_n = 1'b1;
        res_ready = 1'b1;
        nres = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid) nres++;
        end
        check("no_res_after_rst", 32'(nres), 32'(0));
        check("post_rst_cnt", 32'(fifo_cnt), 32'(0));

        // Random traffic: 256 handshakes against the reference queue; done_cnt wraps to 0.
        base = hs_seen;
        fork
            begin
                for (int n = 0; n < 256; n++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)));
                end
                drain(3000);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        res_ready = 1'b1;
        check("rand_handshakes", 32'(hs_seen - base), 32'(256));
        check("done_wrap", 32'(done_cnt), 32'(0));

        // ALU_LAT=3 build: latency 4 edges from push to res_valid.
        c3_res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            c3_cmd_a = vt[i].a;
            c3_cmd_b = vt[i].b;
            c3_cmd_op = vt[i].op;
            c3_cmd_valid = 1'b1;
            @(posedge clk);
            #1 c3_cmd_valid = 1'b0;
            k = 0;
            while (!c3_res_valid && k < 20) begin
                @(posedge clk);
                #1;
                k++;
            end
            check("lat3_latency", 32'(k), 32'(4));
            check("lat3_c", 32'(c3_res_c), 32'(vt[i].c));
            check("lat3_ill", 32'(c3_res_ill), 32'(vt[i].ill));
            @(posedge clk);
            #1;
            check("lat3_done", 32'(c3_done_cnt), 32'(i + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
